// File: rtl/id_ex_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg_pkg
// Description : Shared widths, ALU op encodings and the ID/EX payload bundle
//               used by the ID/EX pipeline register and its hazard detector.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_reg_pkg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 4;

    // ALU operation encodings
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd9;

    // Everything the EX stage receives from decode
    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
    } id_ex_t;

    // A bubble: invalid, no side effects, and all-zero tags so the
    // forwarding comparators can never match against it.
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage : id_ex_stage_reg_pkg
`default_nettype wire

// File: rtl/id_ex_stage_reg_load_use_detector.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detector
// Description : Combinational load-use hazard detection. Flags when the
//               instruction in EX is a load whose destination is read by
//               the valid instruction currently in ID.
// Ports       : i_ex_*   - registered EX-slot state
//               i_id_*   - decode-slot instruction tags and use flags
//               o_hz     - hazard present
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detector (
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    output logic       o_hz
);

    logic w_ex_is_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hard-wired zero, so a load to it can never be a real producer
    assign w_ex_is_load = i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0);
    assign w_rs1_hit    = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit    = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
    assign o_hz         = w_ex_is_load & i_id_valid & (w_rs1_hit | w_rs2_hit);

endmodule : load_use_detector
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register with load-use hazard detection,
//               bubble insertion, same-cycle writeback merge and a
//               saturating count of inserted load-use bubbles.
// Ports       : clk, rst_n          - clock, async active-low reset
//               i_id_*              - decode-stage instruction
//               i_wb_*              - writeback bypass into captured operands
//               i_flush             - redirect, kills the ID instruction
//               i_ex_stall          - EX cannot accept, hold the register
//               o_ex_*              - registered EX payload and tags
//               o_load_use_stall    - hold PC and IF/ID this cycle
//               o_stall_cnt         - inserted load-use bubble count
// Note        : XLEN/ALUOP_W must match the package, which sizes the bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int XLEN    = id_ex_stage_reg_pkg::XLEN,
    parameter int ALUOP_W = id_ex_stage_reg_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_id_valid,
    input  logic [XLEN-1:0]    i_id_pc,
    input  logic [4:0]         i_id_rs1,
    input  logic [4:0]         i_id_rs2,
    input  logic [4:0]         i_id_rd,
    input  logic               i_id_uses_rs1,
    input  logic               i_id_uses_rs2,
    input  logic [XLEN-1:0]    i_id_rs1_data,
    input  logic [XLEN-1:0]    i_id_rs2_data,
    input  logic [XLEN-1:0]    i_id_imm,
    input  logic [ALUOP_W-1:0] i_id_alu_op,
    input  logic               i_id_alu_src,
    input  logic               i_id_reg_write,
    input  logic               i_id_mem_read,
    input  logic               i_id_mem_write,
    input  logic               i_id_mem_to_reg,
    input  logic               i_wb_reg_write,
    input  logic [4:0]         i_wb_rd,
    input  logic [XLEN-1:0]    i_wb_data,
    input  logic               i_flush,
    input  logic               i_ex_stall,
    output logic               o_ex_valid,
    output logic [XLEN-1:0]    o_ex_pc,
    output logic [XLEN-1:0]    o_ex_imm,
    output logic [XLEN-1:0]    o_ex_rs1_data,
    output logic [XLEN-1:0]    o_ex_rs2_data,
    output logic [4:0]         o_ex_rs1,
    output logic [4:0]         o_ex_rs2,
    output logic [4:0]         o_ex_rd,
    output logic [ALUOP_W-1:0] o_ex_alu_op,
    output logic               o_ex_alu_src,
    output logic               o_ex_reg_write,
    output logic               o_ex_mem_read,
    output logic               o_ex_mem_write,
    output logic               o_ex_mem_to_reg,
    output logic               o_load_use_stall,
    output logic [CNT_W-1:0]   o_stall_cnt
);

    id_ex_t             r_ex;
    logic [CNT_W-1:0]   r_stall_cnt;
    id_ex_t             w_cap;
    logic               w_hz;
    logic               w_wb_hit;

    load_use_detector u_load_use_detector (
        .i_ex_valid    (r_ex.valid),
        .i_ex_mem_read (r_ex.mem_read),
        .i_ex_rd       (r_ex.rd),
        .i_id_valid    (i_id_valid),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_uses_rs1 (i_id_uses_rs1),
        .i_id_uses_rs2 (i_id_uses_rs2),
        .o_hz          (w_hz)
    );

    // A writeback to x0 is discarded by the register file, so never merge it
    assign w_wb_hit = i_wb_reg_write & (i_wb_rd != 5'd0);

    // Capture image of the ID slot, with the writeback value bypassed in
    // when the register file is written and read in the same cycle.
    always_comb begin
        w_cap = ID_EX_BUBBLE;
        if (i_id_valid) begin
            w_cap.valid      = 1'b1;
            w_cap.pc         = i_id_pc;
            w_cap.imm        = i_id_imm;
            w_cap.rs1_data   = (w_wb_hit && (i_wb_rd == i_id_rs1)) ? i_wb_data : i_id_rs1_data;
            w_cap.rs2_data   = (w_wb_hit && (i_wb_rd == i_id_rs2)) ? i_wb_data : i_id_rs2_data;
            w_cap.rs1        = i_id_rs1;
            w_cap.rs2        = i_id_rs2;
            w_cap.rd         = i_id_rd;
            w_cap.alu_op     = i_id_alu_op;
            w_cap.alu_src    = i_id_alu_src;
            w_cap.reg_write  = i_id_reg_write;
            w_cap.mem_read   = i_id_mem_read;
            w_cap.mem_write  = i_id_mem_write;
            w_cap.mem_to_reg = i_id_mem_to_reg;
        end
    end

    // Priority: flush > ex_stall > load-use hazard > normal capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= ID_EX_BUBBLE;
            r_stall_cnt <= '0;
        end else if (i_flush) begin
            r_ex        <= ID_EX_BUBBLE;
        end else if (i_ex_stall) begin
            // Held operands would go stale if their producer retires
            // during the hold, so refresh them from writeback.
            if (r_ex.valid && w_wb_hit) begin
                if (i_wb_rd == r_ex.rs1) begin
                    r_ex.rs1_data <= i_wb_data;
                end
                if (i_wb_rd == r_ex.rs2) begin
                    r_ex.rs2_data <= i_wb_data;
                end
            end
        end else if (w_hz) begin
            r_ex <= ID_EX_BUBBLE;
            if (r_stall_cnt != {CNT_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end else begin
            r_ex <= w_cap;
        end
    end

    assign o_ex_valid       = r_ex.valid;
    assign o_ex_pc          = r_ex.pc;
    assign o_ex_imm         = r_ex.imm;
    assign o_ex_rs1_data    = r_ex.rs1_data;
    assign o_ex_rs2_data    = r_ex.rs2_data;
    assign o_ex_rs1         = r_ex.rs1;
    assign o_ex_rs2         = r_ex.rs2;
    assign o_ex_rd          = r_ex.rd;
    assign o_ex_alu_op      = r_ex.alu_op;
    assign o_ex_alu_src     = r_ex.alu_src;
    assign o_ex_reg_write   = r_ex.reg_write;
    assign o_ex_mem_read    = r_ex.mem_read;
    assign o_ex_mem_write   = r_ex.mem_write;
    assign o_ex_mem_to_reg  = r_ex.mem_to_reg;
    assign o_load_use_stall = w_hz & ~i_flush;
    assign o_stall_cnt      = r_stall_cnt;

endmodule : id_ex_stage_reg
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_reg
// Description : Scoreboard bench for id_ex_stage_reg. The driver applies one
//               directed vector per cycle at the falling edge and queues the
//               expected stall flag and post-edge EX state; a monitor pops
//               and compares. The counter is built 5 bits wide so saturation
//               is reachable in a few dozen cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

    localparam int CW = 5;

    // {alu_src, reg_write, mem_read, mem_write, mem_to_reg}
    localparam logic [4:0] C_LW   = 5'b11101;
    localparam logic [4:0] C_ADD  = 5'b01000;
    localparam logic [4:0] C_ADDI = 5'b11000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [4:0]  ctl;
    } ex_t;

    typedef struct {
        ex_t         st;
        logic        lus;
        int          cnt;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_id_valid, i_id_uses_rs1, i_id_uses_rs2;
    logic [31:0] i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm, i_wb_data;
    logic [4:0]  i_id_rs1, i_id_rs2, i_id_rd, i_wb_rd;
    logic [3:0]  i_id_alu_op;
    logic i_id_alu_src, i_id_reg_write, i_id_mem_read, i_id_mem_write, i_id_mem_to_reg;
    logic i_wb_reg_write, i_flush, i_ex_stall;
    logic o_ex_valid;
    logic [31:0] o_ex_pc, o_ex_imm, o_ex_rs1_data, o_ex_rs2_data;
    logic [4:0]  o_ex_rs1, o_ex_rs2, o_ex_rd;
    logic [3:0]  o_ex_alu_op;
    logic o_ex_alu_src, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_mem_to_reg;
    logic o_load_use_stall;
    logic [CW-1:0] o_stall_cnt;

    int total = 0;
    int bad   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(32), .ALUOP_W(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_id_rd(i_id_rd),
        .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
        .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
        .i_id_imm(i_id_imm), .i_id_alu_op(i_id_alu_op),
        .i_id_alu_src(i_id_alu_src), .i_id_reg_write(i_id_reg_write),
        .i_id_mem_read(i_id_mem_read), .i_id_mem_write(i_id_mem_write),
        .i_id_mem_to_reg(i_id_mem_to_reg),
        .i_wb_reg_write(i_wb_reg_write), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_flush(i_flush), .i_ex_stall(i_ex_stall),
        .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_imm(o_ex_imm),
        .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data),
        .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2), .o_ex_rd(o_ex_rd),
        .o_ex_alu_op(o_ex_alu_op), .o_ex_alu_src(o_ex_alu_src),
        .o_ex_reg_write(o_ex_reg_write), .o_ex_mem_read(o_ex_mem_read),
        .o_ex_mem_write(o_ex_mem_write), .o_ex_mem_to_reg(o_ex_mem_to_reg),
        .o_load_use_stall(o_load_use_stall), .o_stall_cnt(o_stall_cnt)
    );

    function automatic ex_t mk(input logic v, input logic [31:0] pc, imm, d1, d2,
                               input logic [4:0] rs1, rs2, rd,
                               input logic [3:0] op, input logic [4:0] ctl);
        ex_t e;
        e.valid = v; e.pc = pc; e.imm = imm; e.d1 = d1; e.d2 = d2;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.op = op; e.ctl = ctl;
        return e;
    endfunction

    function automatic ex_t actual();
        return mk(o_ex_valid, o_ex_pc, o_ex_imm, o_ex_rs1_data, o_ex_rs2_data,
                  o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_alu_op,
                  {o_ex_alu_src, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_mem_to_reg});
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, rs2, rd, input logic u1, u2,
                          input logic [31:0] d1, d2, imm,
                          input logic [3:0] op, input logic [4:0] ctl);
        i_id_valid = v; i_id_pc = pc; i_id_rs1 = rs1; i_id_rs2 = rs2; i_id_rd = rd;
        i_id_uses_rs1 = u1; i_id_uses_rs2 = u2;
        i_id_rs1_data = d1; i_id_rs2_data = d2; i_id_imm = imm; i_id_alu_op = op;
        {i_id_alu_src, i_id_reg_write, i_id_mem_read, i_id_mem_write, i_id_mem_to_reg} = ctl;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        i_wb_reg_write = we; i_wb_rd = rd; i_wb_data = d;
    endtask

    // Called at a falling edge after inputs are applied; returns at the next one
    task automatic expect_cycle(input ex_t e, input logic lus, input int cnt, input string nm);
        exp_t it;
        it.st = e; it.lus = lus; it.cnt = cnt; it.nm = nm;
        q.push_back(it);
        @(negedge clk);
    endtask

    // Monitor: stall flag sampled mid-low-phase, state just after the edge
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                it = q[0];
                chk({it.nm, ".lus"}, 256'(o_load_use_stall), 256'(it.lus));
                @(posedge clk);
                #1;
                chk({it.nm, ".state"}, 256'(actual()), 256'(it.st));
                chk({it.nm, ".cnt"}, 256'(o_stall_cnt), 256'(it.cnt));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ex_t  lw5, hold;
        int   cnt;
        int   n;

        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0);
        set_wb(0, 0, 0);
        i_flush = 0; i_ex_stall = 0;

        @(negedge clk);
        chk("reset.state", 256'(actual()), 256'(ex_t'('0)));
        chk("reset.cnt", 256'(o_stall_cnt), 256'd0);
        chk("reset.lus", 256'(o_load_use_stall), 256'd0);
        rst_n = 1'b1;

        // Load-use: lw x5, then dependent add -> one bubble, then the add
        set_id(1, 32'h100, 2, 0, 5, 1, 0, 32'h1000, 0, 4, 0, C_LW);
        lw5 = mk(1, 32'h100, 4, 32'h1000, 0, 2, 0, 5, 0, C_LW);
        expect_cycle(lw5, 0, 0, "lw");
        set_id(1, 32'h104, 5, 6, 7, 1, 1, 32'h55, 32'h66, 0, 1, C_ADD);
        expect_cycle(ex_t'('0), 1, 1, "lu_bubble");
        expect_cycle(mk(1, 32'h104, 0, 32'h55, 32'h66, 5, 6, 7, 1, C_ADD), 0, 1, "lu_add");

        // Load to x0 never stalls its consumer
        set_id(1, 32'h108, 1, 0, 0, 1, 0, 32'h20, 0, 8, 0, C_LW);
        expect_cycle(mk(1, 32'h108, 8, 32'h20, 0, 1, 0, 0, 0, C_LW), 0, 1, "lw_x0");
        set_id(1, 32'h10C, 0, 3, 9, 1, 1, 0, 32'h33, 0, 1, C_ADD);
        expect_cycle(mk(1, 32'h10C, 0, 0, 32'h33, 0, 3, 9, 1, C_ADD), 0, 1, "x0_use");

        // rs2 matches the load but is not actually read
        set_id(1, 32'h110, 2, 0, 5, 1, 0, 32'h2000, 0, 32'h10, 0, C_LW);
        expect_cycle(mk(1, 32'h110, 32'h10, 32'h2000, 0, 2, 0, 5, 0, C_LW), 0, 1, "lw2");
        set_id(1, 32'h114, 3, 5, 8, 1, 0, 32'h3, 32'h77, 5, 2, C_ADDI);
        expect_cycle(mk(1, 32'h114, 5, 32'h3, 32'h77, 3, 5, 8, 2, C_ADDI), 0, 1, "no_use_rs2");

        // Flush beats ex_stall and a live hazard
        set_id(1, 32'h118, 2, 0, 5, 1, 0, 32'h3000, 0, 0, 0, C_LW);
        expect_cycle(mk(1, 32'h118, 0, 32'h3000, 0, 2, 0, 5, 0, C_LW), 0, 1, "lw3");
        set_id(1, 32'h11C, 5, 6, 7, 1, 1, 32'h1, 32'h2, 0, 1, C_ADD);
        i_flush = 1; i_ex_stall = 1;
        expect_cycle(ex_t'('0), 0, 1, "flush_all");
        i_flush = 0; i_ex_stall = 0;

        // Writeback merge on capture; x0 writeback never merges
        set_id(1, 32'h120, 4, 7, 10, 1, 1, 32'h44, 32'h11, 0, 1, C_ADD);
        set_wb(1, 7, 32'hABCD);
        expect_cycle(mk(1, 32'h120, 0, 32'h44, 32'hABCD, 4, 7, 10, 1, C_ADD), 0, 1, "wb_merge");
        set_id(1, 32'h124, 0, 7, 10, 1, 1, 32'h44, 32'h11, 0, 1, C_ADD);
        set_wb(1, 0, 32'hABCD);
        expect_cycle(mk(1, 32'h124, 0, 32'h44, 32'h11, 0, 7, 10, 1, C_ADD), 0, 1, "wb_x0");

        // Hold for three cycles; writeback to ex_rs1 lands in the second
        set_id(1, 32'h128, 12, 13, 14, 1, 1, 32'h1212, 32'h1313, 0, 1, C_ADD);
        set_wb(0, 0, 0);
        hold = mk(1, 32'h128, 0, 32'h1212, 32'h1313, 12, 13, 14, 1, C_ADD);
        expect_cycle(hold, 0, 1, "pre_hold");
        set_id(1, 32'h200, 1, 2, 3, 1, 1, 32'h9, 32'h9, 32'h9, 3, C_ADD);
        i_ex_stall = 1;
        expect_cycle(hold, 0, 1, "hold1");
        set_wb(1, 12, 32'hBEEF);
        hold.d1 = 32'hBEEF;
        expect_cycle(hold, 0, 1, "hold2");
        set_wb(1, 0, 32'hDEAD);
        expect_cycle(hold, 0, 1, "hold3");
        i_ex_stall = 0;
        set_wb(0, 0, 0);

        // Hazard during ex_stall holds without counting, then bubbles
        set_id(1, 32'h130, 2, 0, 5, 1, 0, 32'h4000, 0, 0, 0, C_LW);
        lw5 = mk(1, 32'h130, 0, 32'h4000, 0, 2, 0, 5, 0, C_LW);
        expect_cycle(lw5, 0, 1, "lw4");
        set_id(1, 32'h134, 1, 5, 7, 1, 1, 32'h1, 32'h2, 0, 1, C_ADD);
        i_ex_stall = 1;
        expect_cycle(lw5, 1, 1, "stall_hz");
        i_ex_stall = 0;
        expect_cycle(ex_t'('0), 1, 2, "hz_after_stall");

        // Invalid ID slot: never a hazard, loads a bubble
        set_id(1, 32'h138, 2, 0, 5, 1, 0, 32'h5000, 0, 0, 0, C_LW);
        expect_cycle(mk(1, 32'h138, 0, 32'h5000, 0, 2, 0, 5, 0, C_LW), 0, 2, "lw5");
        set_id(0, 32'h13C, 5, 5, 7, 1, 1, 32'h1, 32'h2, 3, 1, C_ADD);
        expect_cycle(ex_t'('0), 0, 2, "id_invalid");

        // Drive the counter into saturation and past it
        cnt = 2;
        for (int i = 0; i < 32; i++) begin
            set_id(1, 32'h400 + 32'(i), 2, 0, 5, 1, 0, 32'(i), 0, 0, 0, C_LW);
            expect_cycle(mk(1, 32'h400 + 32'(i), 0, 32'(i), 0, 2, 0, 5, 0, C_LW), 0, cnt, "sat_lw");
            set_id(1, 32'h500, 5, 0, 6, 1, 0, 0, 0, 0, 1, C_ADD);
            cnt = (cnt < 31) ? cnt + 1 : 31;
            expect_cycle(ex_t'('0), 1, cnt, "sat_hz");
        end

        // Reset asserted mid-stall with a valid load held
        set_id(1, 32'h600, 2, 0, 5, 1, 0, 32'h6000, 0, 0, 0, C_LW);
        expect_cycle(mk(1, 32'h600, 0, 32'h6000, 0, 2, 0, 5, 0, C_LW), 0, 31, "pre_rst");
        set_id(1, 32'h604, 5, 0, 6, 1, 0, 0, 0, 0, 1, C_ADD);
        i_ex_stall = 1;
        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 256'(q.size()), 256'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst.state", 256'(actual()), 256'(ex_t'('0)));
        chk("async_rst.cnt", 256'(o_stall_cnt), 256'd0);
        chk("async_rst.lus", 256'(o_load_use_stall), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        i_ex_stall = 0;
        set_id(1, 32'h700, 3, 4, 8, 1, 1, 32'h77, 32'h88, 1, 4, C_ADD);
        expect_cycle(mk(1, 32'h700, 1, 32'h77, 32'h88, 3, 4, 8, 4, C_ADD), 0, 0, "post_rst");

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("final_drain", 256'(q.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_id_ex_stage_reg
`default_nettype wire
